// File: rtl/gpio_btn_pkg.sv
// Shared definitions for the GPIO button/LED scanner.
// Holds the scan FSM state encoding, the default parameter values used by
// gpio_btn_scan, and a small helper that sizes counters from their maximum.
package gpio_btn_pkg;

  // Scan sequence for one channel: DRIVE -> SETTLE -> SAMPLE -> NEXT
  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    NEXT
  } scan_state_t;

  localparam int NCH_DEF        = 9;
  localparam int DRIVE_CYC_DEF  = 1000;
  localparam int SETTLE_CYC_DEF = 8;
  localparam int DEB_N_DEF      = 4;

  // Number of bits needed to hold the values 0..maxVal (never less than 1)
  function automatic int widthFor(input int maxVal);
    return (maxVal <= 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/gpio_btn_deb.sv
// Single-channel debouncer for one shared button/LED pin.
// Ports:
//   clock_50    system clock
//   reset_n     synchronous active-low reset
//   i_sampleEn  one-cycle strobe: i_sample is a fresh sample for this channel
//   i_sample    synchronized pin level captured by the scanner
//   o_ledg      debounced level (resets high = button released)
//   o_press     one-cycle pulse when o_ledg falls 1->0
module gpio_btn_deb
  import gpio_btn_pkg::*;
#(
  parameter int DEB_N = DEB_N_DEF
) (
  input  logic clock_50,
  input  logic reset_n,
  input  logic i_sampleEn,
  input  logic i_sample,
  output logic o_ledg,
  output logic o_press
);

  localparam int CW = widthFor(DEB_N);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntInc;
  logic          w_differs;
  logic          w_reached;

  // The increment saturates at DEB_N so the counter can never wrap, even
  // though in normal operation reaching DEB_N clears it straight away.
  assign w_differs = (i_sample != o_ledg);
  assign w_cntInc  = (r_cnt == CW'(DEB_N)) ? r_cnt : r_cnt + CW'(1);
  assign w_reached = (w_cntInc == CW'(DEB_N));

  // A differing sample counts up; a matching one forgets any partial run.
  // When the run reaches DEB_N the level flips, and a falling flip is
  // reported as a press in the same cycle the level changes.
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      o_ledg  <= 1'b1;
      o_press <= 1'b0;
    end else begin
      o_press <= 1'b0;
      if (i_sampleEn) begin
        if (w_differs) begin
          if (w_reached) begin
            o_ledg  <= ~o_ledg;
            r_cnt   <= '0;
            o_press <= o_ledg;
          end else begin
            r_cnt <= w_cntInc;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_btn_scan.sv
// Time-multiplexed scanner for NCH pins that each drive an LED and read a
// button. Pins are normally driven high; one at a time a pin is released,
// allowed to settle, sampled, and its sample fed to that channel's debouncer.
// Ports:
//   clock_50  system clock
//   reset_n   synchronous active-low reset
//   enable    level-sensitive scan enable
//   gpio_in   raw pin levels (asynchronous)
//   gpio_out  pin drive value, always all-ones
//   gpio_oe   per-pin output enable, 1 = driven, 0 = released
//   ledg      debounced level per channel
//   press     one-cycle pulse per channel on a debounced 1->0 change
module gpio_btn_scan
  import gpio_btn_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int DRIVE_CYC  = DRIVE_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int DEB_N      = DEB_N_DEF
) (
  input  logic           clock_50,
  input  logic           reset_n,
  input  logic           enable,
  input  logic [NCH-1:0] gpio_in,
  output logic [NCH-1:0] gpio_out,
  output logic [NCH-1:0] gpio_oe,
  output logic [NCH-1:0] ledg,
  output logic [NCH-1:0] press
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW  = widthFor((DRIVE_CYC > SETTLE_CYC) ? DRIVE_CYC : SETTLE_CYC);

  localparam logic [TW-1:0]  DRIVE_LAST  = TW'(DRIVE_CYC - 1);
  localparam logic [TW-1:0]  SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [CHW-1:0] CH_LAST     = CHW'(NCH - 1);

  scan_state_t    r_state;
  scan_state_t    w_stateNext;
  logic [CHW-1:0] r_ch;
  logic [CHW-1:0] w_chNext;
  logic [TW-1:0]  r_tmr;
  logic [TW-1:0]  w_tmrNext;
  logic           w_sampleEn;
  logic [NCH-1:0] w_relMask;
  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;
  logic [NCH-1:0] w_chSel;

  assign gpio_out = '1;

  // Only the current channel is ever released, so the mask has one zero.
  assign w_relMask = ~(NCH'(1) << r_ch);

  // Two-flop synchronizer on the raw pins. It resets to all-ones so that a
  // freshly reset scanner sees "released" buttons rather than presses.
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  // Scan state, current channel and the shared DRIVE/SETTLE cycle timer.
  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_ch    <= w_chNext;
      r_tmr   <= w_tmrNext;
    end
  end

  // Next-state and pin-enable decode. enable is only looked at in IDLE and
  // NEXT, so a channel that has started always runs to completion and no
  // partially settled sample is ever taken. The channel index is kept across
  // IDLE so a resumed scan carries on where it stopped.
  always_comb begin
    w_stateNext = r_state;
    w_chNext    = r_ch;
    w_tmrNext   = r_tmr;
    w_sampleEn  = 1'b0;
    gpio_oe     = '1;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_stateNext = DRIVE;
          w_tmrNext   = '0;
        end
      end
      DRIVE: begin
        if (r_tmr == DRIVE_LAST) begin
          w_stateNext = SETTLE;
          w_tmrNext   = '0;
        end else begin
          w_tmrNext = r_tmr + TW'(1);
        end
      end
      SETTLE: begin
        gpio_oe = w_relMask;
        if (r_tmr == SETTLE_LAST) begin
          w_stateNext = SAMPLE;
          w_tmrNext   = '0;
        end else begin
          w_tmrNext = r_tmr + TW'(1);
        end
      end
      SAMPLE: begin
        gpio_oe     = w_relMask;
        w_sampleEn  = 1'b1;
        w_stateNext = NEXT;
      end
      NEXT: begin
        w_chNext    = (r_ch == CH_LAST) ? '0 : r_ch + CHW'(1);
        w_tmrNext   = '0;
        w_stateNext = enable ? DRIVE : IDLE;
      end
      default: begin
        w_stateNext = IDLE;
        w_tmrNext   = '0;
      end
    endcase
  end

  // One debouncer per channel; only the channel being sampled is strobed,
  // so every other channel holds its level and run count.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_deb
    assign w_chSel[gi] = w_sampleEn && (r_ch == CHW'(gi));

    gpio_btn_deb #(
      .DEB_N(DEB_N)
    ) u_deb (
      .clock_50  (clock_50),
      .reset_n   (reset_n),
      .i_sampleEn(w_chSel[gi]),
      .i_sample  (r_sync2[gi]),
      .o_ledg    (ledg[gi]),
      .o_press   (press[gi])
    );
  end

endmodule

// File: tb/tb_gpio_btn_scan.sv
// Self-checking bench for gpio_btn_scan with NCH=9, DRIVE_CYC=4,
// SETTLE_CYC=3, DEB_N=2 (9-cycle channel slot).
// A slot-position model predicts every output each cycle; directed
// scenarios add hand-computed expectations on top of it.
module tb_gpio_btn_scan;

  localparam int NCH        = 9;
  localparam int DRV        = 4;
  localparam int SET        = 3;
  localparam int DEB        = 2;
  localparam int SAMPLE_POS = DRV + SET;
  localparam int NEXT_POS   = DRV + SET + 1;

  logic           clock_50 = 1'b0;
  logic           reset_n;
  logic           enable;
  logic [NCH-1:0] gpio_in;
  logic [NCH-1:0] gpio_out;
  logic [NCH-1:0] gpio_oe;
  logic [NCH-1:0] ledg;
  logic [NCH-1:0] press;

  int errors = 0;
  int checks = 0;
  bit checkOn = 1'b0;

  gpio_btn_scan #(
    .NCH       (NCH),
    .DRIVE_CYC (DRV),
    .SETTLE_CYC(SET),
    .DEB_N     (DEB)
  ) dut (
    .clock_50(clock_50),
    .reset_n (reset_n),
    .enable  (enable),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .ledg    (ledg),
    .press   (press)
  );

  always #5 clock_50 = ~clock_50;

  // Reference model: the scan is a position 0..SLOT-1 inside the current
  // channel's slot (0..3 drive, 4..6 settle, 7 sample, 8 next), plus the
  // debounce rules applied to a two-cycle-delayed copy of the pins.
  bit             mActive = 1'b0;
  int             mCh     = 0;
  int             mPos    = 0;
  logic [NCH-1:0] mLedg   = '1;
  logic [NCH-1:0] mPress  = '0;
  logic [NCH-1:0] mSync1  = '1;
  logic [NCH-1:0] mSync2  = '1;
  int             mCnt[NCH];

  always @(posedge clock_50) begin
    if (!reset_n) begin
      mActive = 1'b0;
      mCh     = 0;
      mPos    = 0;
      mLedg   = '1;
      mPress  = '0;
      mSync1  = '1;
      mSync2  = '1;
      for (int k = 0; k < NCH; k++) mCnt[k] = 0;
    end else begin
      mPress = '0;
      if (mActive && mPos == SAMPLE_POS) begin
        if (mSync2[mCh] != mLedg[mCh]) begin
          mCnt[mCh] = mCnt[mCh] + 1;
          if (mCnt[mCh] == DEB) begin
            mCnt[mCh] = 0;
            if (mLedg[mCh]) mPress[mCh] = 1'b1;
            mLedg[mCh] = ~mLedg[mCh];
          end
        end else begin
          mCnt[mCh] = 0;
        end
      end
      if (!mActive) begin
        if (enable) begin
          mActive = 1'b1;
          mPos    = 0;
        end
      end else if (mPos == NEXT_POS) begin
        mCh  = (mCh + 1) % NCH;
        mPos = 0;
        if (!enable) mActive = 1'b0;
      end else begin
        mPos = mPos + 1;
      end
      mSync2 = mSync1;
      mSync1 = gpio_in;
    end
  end

  function automatic logic [NCH-1:0] modelOe();
    logic [NCH-1:0] one;
    one = 1;
    if (mActive && mPos >= DRV && mPos <= SAMPLE_POS) return ~(one << mCh);
    return '1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic en, input logic [NCH-1:0] pins);
    reset_n = rstN;
    enable  = en;
    gpio_in = pins;
  endtask

  // Per-cycle comparison against the model, plus the pin invariants.
  always @(negedge clock_50) begin
    if (checkOn) begin
      checkOutput("gpio_oe", 32'(gpio_oe), 32'(modelOe()));
      checkOutput("ledg", 32'(ledg), 32'(mLedg));
      checkOutput("press", 32'(press), 32'(mPress));
      checkOutput("gpio_out", 32'(gpio_out), 32'h1FF);
      checkOutput("oeAtMostOneZero", 32'($countones(~gpio_oe) <= 1), 32'd1);
    end
  end

  // Advance at least one cycle, then until the model reaches channel ch
  // (any channel if ch<0) at slot position pos.
  task automatic waitSlot(input int ch, input int pos, input string tag);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    do begin
      @(negedge clock_50);
      n++;
      hit = mActive && (ch < 0 || mCh == ch) && mPos == pos;
    end while (!hit && n < 400);
    if (!hit) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Wait until some pin is released and report the enable pattern seen.
  task automatic waitOeLow(output logic [NCH-1:0] seen);
    int n;
    n    = 0;
    seen = '1;
    do begin
      @(negedge clock_50);
      n++;
      seen = gpio_oe;
    end while (seen == '1 && n < 200);
  endtask

  int             lowCnt[NCH];
  int             lowCh2;
  logic [NCH-1:0] seenOe;

  initial begin
    applyStimulus(1'b0, 1'b0, '1);
    repeat (3) @(negedge clock_50);
    checkOn = 1'b1;
    checkOutput("rstOe", 32'(gpio_oe), 32'h1FF);
    checkOutput("rstLedg", 32'(ledg), 32'h1FF);
    checkOutput("rstPress", 32'(press), 32'h000);

    // Idle pins: each pin released for 4 of its 9 cycles, channel 0 first
    applyStimulus(1'b1, 1'b1, '1);
    for (int k = 0; k < NCH; k++) lowCnt[k] = 0;
    for (int c = 0; c < 9 * NCH; c++) begin
      @(negedge clock_50);
      for (int k = 0; k < NCH; k++) if (!gpio_oe[k]) lowCnt[k]++;
      if (c == DRV) checkOutput("firstRelease", 32'(gpio_oe), 32'h1FE);
    end
    for (int k = 0; k < NCH; k++) checkOutput($sformatf("lowCycles%0d", k), 32'(lowCnt[k]), 32'd4);
    checkOutput("idleLedg", 32'(ledg), 32'h1FF);

    // Button 3 held: falls after the second low sample of channel 3
    waitSlot(3, 2, "ch3hold");
    applyStimulus(1'b1, 1'b1, 9'h1F7);
    waitSlot(3, NEXT_POS, "ch3first");
    checkOutput("ch3AfterOne", 32'(ledg), 32'h1FF);
    waitSlot(3, NEXT_POS, "ch3second");
    checkOutput("ch3Fall", 32'(ledg), 32'h1F7);
    checkOutput("ch3Press", 32'(press), 32'h008);
    @(negedge clock_50);
    checkOutput("ch3PressEnd", 32'(press), 32'h000);

    // Button 5 glitch: low, high, low samples must never flip it
    waitSlot(5, 2, "ch5glitchA");
    applyStimulus(1'b1, 1'b1, 9'h1D7);
    waitSlot(5, NEXT_POS, "ch5sampleA");
    applyStimulus(1'b1, 1'b1, 9'h1F7);
    checkOutput("ch5AfterGlitch", 32'(ledg), 32'h1F7);
    waitSlot(5, NEXT_POS, "ch5clean");
    waitSlot(5, 2, "ch5glitchB");
    applyStimulus(1'b1, 1'b1, 9'h1D7);
    waitSlot(5, NEXT_POS, "ch5sampleB");
    applyStimulus(1'b1, 1'b1, 9'h1F7);
    checkOutput("ch5Held", 32'(ledg), 32'h1F7);

    // Enable dropped during channel 2 drive: channel 2 still completes
    waitSlot(2, 1, "ch2drop");
    applyStimulus(1'b1, 1'b0, 9'h1F7);
    lowCh2 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock_50);
      if (gpio_oe == 9'h1FB) lowCh2++;
    end
    checkOutput("ch2Finished", 32'(lowCh2), 32'd4);
    checkOutput("idleOe", 32'(gpio_oe), 32'h1FF);
    applyStimulus(1'b1, 1'b1, 9'h1F7);
    waitOeLow(seenOe);
    checkOutput("resumeAtCh3", 32'(seenOe), 32'h1F7);

    // Reset in the middle of a settle window with ledg[3] low
    waitSlot(-1, DRV + 1, "settleRst");
    checkOutput("preRstLedg3", 32'(ledg[3]), 32'd0);
    applyStimulus(1'b0, 1'b1, 9'h1F7);
    @(negedge clock_50);
    checkOutput("postRstOe", 32'(gpio_oe), 32'h1FF);
    checkOutput("postRstLedg", 32'(ledg), 32'h1FF);
    checkOutput("postRstPress", 32'(press), 32'h000);
    applyStimulus(1'b1, 1'b1, 9'h1F7);
    waitOeLow(seenOe);
    checkOutput("restartAtCh0", 32'(seenOe), 32'h1FE);

    // Let button 3 be debounced again from the reset state
    repeat (2 * 9 * NCH) @(negedge clock_50);
    checkOutput("ch3FallAgain", 32'(ledg), 32'h1F7);

    checkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/gpio_btn_scan.md
GPIO_BTN_SCAN -- requirements
Module: gpio_btn_scan

Interface
REQ-001 Parameter NCH, default 9: number of shared GPIO button/LED channels.
REQ-002 Parameter DRIVE_CYC, default 1000: cycles all pins are driven high between samples.
REQ-003 Parameter SETTLE_CYC, default 8: cycles a released pin floats before sampling; legal range is at least 3.
REQ-004 Parameter DEB_N, default 4: consecutive differing samples required to change the debounced state; legal range is at least 1.
REQ-005 clock_50  in  1  system clock; one clock domain; reset is synchronous and active-low.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 enable  in  1  scan enable, level-sensitive.
REQ-008 gpio_in  in  NCH  raw pin levels, asynchronous to clock_50.
REQ-009 gpio_out  out  NCH  pin drive value, constant all-ones.
REQ-010 gpio_oe  out  NCH  per-pin output enable; 1 = driven, 0 = released (high-Z at top level).
REQ-011 ledg  out  NCH  debounced pin level per channel, registered.
REQ-012 press  out  NCH  one-cycle pulse on a debounced 1->0 transition.

Function
REQ-013 gpio_in SHALL pass through a 2-flop synchronizer; all sampling uses the synchronizer output.
REQ-014 The FSM SHALL have states IDLE, DRIVE, SETTLE, SAMPLE and NEXT, plus a channel index ch in the range 0..NCH-1 and a cycle counter.
REQ-015 IDLE: all gpio_oe=1; when enable=1, the FSM enters DRIVE on the next cycle with the counter cleared.
REQ-016 DRIVE: all gpio_oe=1 for exactly DRIVE_CYC cycles, then SETTLE.
REQ-017 SETTLE: gpio_oe[ch]=0 and all other bits=1 for exactly SETTLE_CYC cycles, then SAMPLE.
REQ-018 SAMPLE (1 cycle): gpio_oe[ch] stays 0; the synchronized gpio_in[ch] is captured into the debouncer for ch.
REQ-019 NEXT (1 cycle): all gpio_oe=1; ch increments and wraps from NCH-1 to 0; the FSM goes to DRIVE if enable=1, else IDLE.
REQ-020 Per-channel period SHALL be DRIVE_CYC+SETTLE_CYC+2 cycles; full scan period = NCH times that.
REQ-021 At most one gpio_oe bit SHALL be 0 in any cycle (invariant).
REQ-022 Debounce: each sample that differs from ledg[ch] increments cnt[ch]; a matching sample clears cnt[ch]; when cnt[ch] reaches DEB_N, ledg[ch] toggles and cnt[ch] clears, all in the cycle after SAMPLE.
REQ-023 cnt width SHALL be clog2(DEB_N+1); the counter saturates and never wraps.
REQ-024 press[ch] SHALL be 1 for exactly one cycle, coincident with ledg[ch] changing 1->0; 0->1 changes produce no pulse.
REQ-025 Channels other than ch SHALL hold their ledg and cnt unchanged.
REQ-026 enable deasserting mid-channel: the current channel completes through NEXT, then IDLE; no truncated sample is taken.
REQ-027 enable reasserting in IDLE: the scan resumes at the stored ch, not at 0.
REQ-028 gpio_out SHALL be all-ones at all times.

Reset
REQ-029 reset_n=0 at a clock edge SHALL, from any state, force: state=IDLE, ch=0, counter=0, all cnt=0, gpio_oe all-ones, ledg all-ones, press all-zeros, synchronizer flops all-ones.

Structure
REQ-030 Package gpio_btn_pkg SHALL hold the FSM state enum and the parameter defaults.
REQ-031 Sub-module gpio_btn_deb SHALL implement a single-channel debouncer (REQ-022..024) and be instantiated NCH times.

Verification (NCH=9, DRIVE_CYC=4, SETTLE_CYC=3, DEB_N=2; period 9 cycles)
REQ-032 Reset released, enable=1, gpio_in all-ones -> gpio_oe bit k low for exactly 4 cycles per 9-cycle slot in order 0..8 then 0; ledg stays 0x1FF; press stays 0.
REQ-033 gpio_in[3]=0 held -> ledg[3] falls and press[3] pulses once, 1 cycle after the 2nd ch=3 SAMPLE; other bits are unchanged.
REQ-034 gpio_in[5] glitches low for one ch=5 sample only -> ledg[5] stays 1 and cnt[5] returns to 0.
REQ-035 enable dropped during ch=2 DRIVE -> ch=2 finishes SETTLE, SAMPLE and NEXT, then IDLE; on re-enable the scan resumes at ch=3.
REQ-036 reset_n=0 during SETTLE with ledg[3]=0 -> next cycle gpio_oe=0x1FF, ledg=0x1FF, state IDLE, ch=0.
REQ-037 Every cycle, the bench SHALL check that gpio_oe has at most one zero bit and gpio_out=0x1FF.
